// File: rtl/seq_multiplier_32bit.sv
// Iterative shift-add multiplier, one partial product per clock, with signed/unsigned modes.
// Signed operands are reduced to magnitudes up front and the sign is applied once at completion.
module seq_multiplier_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] product_hi
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_t             state_reg;
    logic               neg_reg;
    logic [WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    // Bit 0 of the running accumulator is only ever needed on the final
    // iteration, where it is taken straight from acc_next.
    logic [2*WIDTH-1:1] acc_reg;
    logic [CW-1:0]      count_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   product_lo_reg;
    logic [WIDTH-1:0]   product_hi_reg;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   pp;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod_final;
    logic               last_iter;

    // Two's-complement negate of 0x80..0 yields 0x80..0, which is the correct unsigned magnitude.
    always_comb begin
        abs_a = (signed_op && a[WIDTH-1]) ? (~a + ONE_W) : a;
        abs_b = (signed_op && b[WIDTH-1]) ? (~b + ONE_W) : b;
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
            assign pp[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    always_comb begin
        sum        = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, pp};
        acc_next   = {sum, acc_reg[WIDTH-1:1]};
        prod_final = neg_reg ? (~acc_next + ONE_2W) : acc_next;
        last_iter  = (count_reg == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            neg_reg        <= 1'b0;
            mcand_reg      <= '0;
            mplier_reg     <= '0;
            acc_reg        <= '0;
            count_reg      <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            product_lo_reg <= '0;
            product_hi_reg <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    // DONE behaves like IDLE for accepting a new request.
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                    if (start) begin
                        neg_reg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        mcand_reg  <= abs_a;
                        mplier_reg <= abs_b;
                        acc_reg    <= '0;
                        count_reg  <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    acc_reg    <= acc_next[2*WIDTH-1:1];
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg + CW'(1);
                    if (last_iter) begin
                        state_reg      <= DONE;
                        busy_reg       <= 1'b0;
                        done_reg       <= 1'b1;
                        product_hi_reg <= prod_final[2*WIDTH-1:WIDTH];
                        product_lo_reg <= prod_final[WIDTH-1:0];
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign product_lo = product_lo_reg;
    assign product_hi = product_hi_reg;

endmodule
